// File: rtl/maxpool_pair_feeder.sv
// maxpool_pair_feeder: turns a raster pixel stream into vertically aligned
// pixel pairs for a 2x2 max-pool. Even rows are parked in a line buffer.
// While the next odd row streams in, each odd-row pixel leaves together with
// the buffered pixel from the same column.
module maxpool_pair_feeder #(
   parameter int dataColNum = 28,
   parameter int dataRowNum = 28,
   parameter int wordlength = 16,
   parameter int col_length = 5
) (
   input  logic                         clk,
   input  logic                         irst_n,
   input  logic                         in_valid,
   input  logic signed [wordlength-1:0] pixel_in,
   output logic signed [wordlength-1:0] pixels_0,
   output logic signed [wordlength-1:0] pixels_1,
   output logic                         out_valid,
   output logic                         frame_done
);

   localparam int ROW_W  = $clog2(dataRowNum + 1);
   localparam int IDX_W  = (dataColNum > 1) ? $clog2(dataColNum) : 1;
   localparam bit ODD_ROWS = (dataRowNum % 2) == 1;

   localparam logic [col_length-1:0] COL_LAST  = col_length'(dataColNum - 1);
   localparam logic [ROW_W-1:0]      ROW_END   = ROW_W'(dataRowNum);
   localparam logic [ROW_W-1:0]      ROW_DRAIN = ROW_W'(dataRowNum - 1);

   typedef enum logic [1:0] {FILL, EMIT, DRAIN} state_t;

   state_t                        state, nxt_state;
   logic [col_length-1:0]         col, nxt_col;
   logic [ROW_W-1:0]              row, nxt_row, row_inc;
   logic signed [wordlength-1:0]  nxt_p0, nxt_p1;
   logic                          nxt_vld, nxt_fd;
   logic                          lb_we;
   logic                          col_last;
   logic [IDX_W-1:0]              col_idx;

   // One even row of storage; contents are only meaningful after a FILL row.
   logic signed [wordlength-1:0]  linebuf [dataColNum];

   assign col_last = (col == COL_LAST);
   assign col_idx  = col[IDX_W-1:0];
   assign row_inc  = row + ROW_W'(1);

   // Next-state, counter and output-register values; idle cycles hold all
   // state and drop out_valid while the pixel outputs keep their last pair.
   always_comb begin
      nxt_state = state;
      nxt_col   = col;
      nxt_row   = row;
      nxt_p0    = pixels_0;
      nxt_p1    = pixels_1;
      nxt_vld   = 1'b0;
      nxt_fd    = 1'b0;
      lb_we     = 1'b0;
      if (in_valid) begin
         nxt_col = col_last ? '0 : col + col_length'(1);
         case (state)
            FILL: begin
               lb_we = 1'b1;
               if (col_last) begin
                  nxt_row   = row_inc;
                  nxt_state = EMIT;
               end
            end
            EMIT: begin
               nxt_p0  = linebuf[col_idx];
               nxt_p1  = pixel_in;
               nxt_vld = 1'b1;
               if (col_last) begin
                  if (ODD_ROWS && (row_inc == ROW_DRAIN)) begin
                     // Last full row pair done; the leftover odd row is dropped.
                     nxt_row   = row_inc;
                     nxt_state = DRAIN;
                     nxt_fd    = 1'b1;
                  end else if (row_inc == ROW_END) begin
                     nxt_row   = '0;
                     nxt_state = FILL;
                     nxt_fd    = 1'b1;
                  end else begin
                     nxt_row   = row_inc;
                     nxt_state = FILL;
                  end
               end
            end
            DRAIN: begin
               if (col_last) begin
                  nxt_row   = '0;
                  nxt_state = FILL;
               end
            end
            default: begin
               nxt_state = FILL;
               nxt_col   = '0;
               nxt_row   = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs; reset aborts any partial row.
   always_ff @(posedge clk or negedge irst_n) begin
      if (!irst_n) begin
         state      <= FILL;
         col        <= '0;
         row        <= '0;
         pixels_0   <= '0;
         pixels_1   <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         col        <= nxt_col;
         row        <= nxt_row;
         pixels_0   <= nxt_p0;
         pixels_1   <= nxt_p1;
         out_valid  <= nxt_vld;
         frame_done <= nxt_fd;
      end
   end

   // Even-row capture; no reset since stale contents are never read before
   // being rewritten by the next FILL row.
   always_ff @(posedge clk) begin
      if (lb_we) linebuf[col_idx] <= pixel_in;
   end

endmodule

// File: tb/tb_maxpool_pair_feeder.sv
// Scoreboard bench for maxpool_pair_feeder: a 4x4 instance for even row
// counts and a 4x3 instance for the odd-row-count drain path.
module tb_maxpool_pair_feeder;

   typedef struct {
      int p0;
      int p1;
      bit fd;
   } pair_t;

   logic clk = 1'b0;
   logic irst_n = 1'b0;

   logic               vin_e = 1'b0, vin_o = 1'b0;
   logic signed [15:0] pin_e = '0, pin_o = '0;
   logic signed [15:0] p0_e, p1_e, p0_o, p1_o;
   logic               vld_e, fd_e, vld_o, fd_o;

   pair_t q_e[$];
   pair_t q_o[$];

   int checks = 0;
   int errors = 0;
   int n_pair_e = 0;
   int n_fd_e = 0;
   int last_fd_pair_e = 0;
   int fd_gap_e = 0;

   always #5 clk = ~clk;

   maxpool_pair_feeder #(
      .dataColNum(4), .dataRowNum(4), .wordlength(16), .col_length(5)
   ) dut_e (
      .clk(clk), .irst_n(irst_n), .in_valid(vin_e), .pixel_in(pin_e),
      .pixels_0(p0_e), .pixels_1(p1_e), .out_valid(vld_e), .frame_done(fd_e)
   );

   maxpool_pair_feeder #(
      .dataColNum(4), .dataRowNum(3), .wordlength(16), .col_length(5)
   ) dut_o (
      .clk(clk), .irst_n(irst_n), .in_valid(vin_o), .pixel_in(pin_o),
      .pixels_0(p0_o), .pixels_1(p1_o), .out_valid(vld_o), .frame_done(fd_o)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Even-instance scoreboard: pop and compare every pair the DUT presents.
   always @(negedge clk) begin
      pair_t p;
      if (irst_n && vld_e) begin
         if (q_e.size() == 0) chk("sb_e_spurious", 1, 0);
         else begin
            p = q_e.pop_front();
            chk("p0_e", int'(p0_e), p.p0);
            chk("p1_e", int'(p1_e), p.p1);
            chk("fd_e", int'(fd_e), int'(p.fd));
            n_pair_e++;
            if (fd_e) begin
               n_fd_e++;
               fd_gap_e = n_pair_e - last_fd_pair_e;
               last_fd_pair_e = n_pair_e;
            end
         end
      end else if (irst_n && fd_e) chk("fd_e_no_vld", 1, 0);
   end

   // Odd-instance scoreboard.
   always @(negedge clk) begin
      pair_t p;
      if (irst_n && vld_o) begin
         if (q_o.size() == 0) chk("sb_o_spurious", 1, 0);
         else begin
            p = q_o.pop_front();
            chk("p0_o", int'(p0_o), p.p0);
            chk("p1_o", int'(p1_o), p.p1);
            chk("fd_o", int'(fd_o), int'(p.fd));
         end
      end else if (irst_n && fd_o) chk("fd_o_no_vld", 1, 0);
   end

   // Drive one pixel and check that the pair (if any) lands one cycle later.
   task automatic send_e(input int pix, input bit exp_v);
      vin_e = 1'b1;
      pin_e = 16'(pix);
      @(posedge clk);
      #1;
      chk("vld_e", int'(vld_e), int'(exp_v));
      if (!exp_v) chk("fd_idle_e", int'(fd_e), 0);
   endtask

   task automatic send_o(input int pix, input bit exp_v);
      vin_o = 1'b1;
      pin_o = 16'(pix);
      @(posedge clk);
      #1;
      chk("vld_o", int'(vld_o), int'(exp_v));
      if (!exp_v) chk("fd_idle_o", int'(fd_o), 0);
   endtask

   task automatic idle_e(input int n);
      vin_e = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("idle_vld_e", int'(vld_e), 0);
      end
   endtask

   // 4x4 frame of base+0..15; optional 3-cycle gap in the middle of row 0.
   task automatic frame_e(input int base, input bit gaps);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (r % 2 == 1)
               q_e.push_back('{p0: base + (r-1)*4 + c, p1: base + r*4 + c,
                               fd: (r == 3 && c == 3)});
            send_e(base + r*4 + c, r % 2 == 1);
            if (gaps && r == 0 && c == 1) idle_e(3);
         end
   endtask

   // 4x3 frame: rows 0/1 pair up, row 2 is swallowed.
   task automatic frame_o(input int base);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) begin
            if (r == 1)
               q_o.push_back('{p0: base + c, p1: base + 4 + c, fd: (c == 3)});
            send_o(base + r*4 + c, r == 1);
         end
   endtask

   initial begin
      int r0 [4];
      int r1 [4];
      int pairs0;
      int fds0;
      r0 = '{-32768, -1, 5, 32767};
      r1 = '{1, -2, -32768, 0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_p0_e", int'(p0_e), 0);
      chk("rst_p1_e", int'(p1_e), 0);
      chk("rst_vld_e", int'(vld_e), 0);
      chk("rst_fd_e", int'(fd_e), 0);
      chk("rst_vld_o", int'(vld_o), 0);
      chk("rst_fd_o", int'(fd_o), 0);
      @(negedge clk);
      irst_n = 1'b1;

      // 1: plain 4x4 frame
      frame_e(0, 1'b0);
      idle_e(2);
      chk("s1_sb_empty", q_e.size(), 0);

      // 2: signed extremes, rows 2/3 complete the frame
      for (int c = 0; c < 4; c++) send_e(r0[c], 1'b0);
      for (int c = 0; c < 4; c++) begin
         q_e.push_back('{p0: r0[c], p1: r1[c], fd: 1'b0});
         send_e(r1[c], 1'b1);
      end
      for (int c = 0; c < 4; c++) send_e(7 + c, 1'b0);
      for (int c = 0; c < 4; c++) begin
         q_e.push_back('{p0: 7 + c, p1: -7 - c, fd: (c == 3)});
         send_e(-7 - c, 1'b1);
      end
      idle_e(2);
      chk("s2_sb_empty", q_e.size(), 0);

      // 3: gaps inside even row
      frame_e(0, 1'b1);
      idle_e(2);
      chk("s3_sb_empty", q_e.size(), 0);

      // 4: odd row count, two frames back to back
      frame_o(0);
      frame_o(12);
      vin_o = 1'b0;
      @(posedge clk);
      #1;
      chk("s4_vld_o_after", int'(vld_o), 0);
      @(negedge clk);
      chk("s4_sb_empty", q_o.size(), 0);

      // 5: reset two pixels into row 1, then a clean frame
      for (int c = 0; c < 4; c++) send_e(c, 1'b0);
      for (int c = 0; c < 2; c++) begin
         q_e.push_back('{p0: c, p1: 4 + c, fd: 1'b0});
         send_e(4 + c, 1'b1);
      end
      @(negedge clk);
      #1;
      irst_n = 1'b0;
      vin_e = 1'b0;
      #1;
      chk("s5_rst_p0", int'(p0_e), 0);
      chk("s5_rst_p1", int'(p1_e), 0);
      chk("s5_rst_vld", int'(vld_e), 0);
      chk("s5_sb_empty_rst", q_e.size(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      irst_n = 1'b1;
      frame_e(0, 1'b0);
      idle_e(2);
      chk("s5_sb_empty", q_e.size(), 0);

      // 6: two frames with no gap
      pairs0 = n_pair_e;
      fds0 = n_fd_e;
      frame_e(100, 1'b0);
      frame_e(200, 1'b0);
      idle_e(2);
      chk("s6_pairs", n_pair_e - pairs0, 16);
      chk("s6_fd_count", n_fd_e - fds0, 2);
      chk("s6_fd_gap", fd_gap_e, 8);
      chk("s6_sb_empty", q_e.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
